// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared types for the FPU-subsystem writeback path
// Purpose: writeback entry layout shared by the arbiter and its CSR result FIFO.
// Ports: none (package).
package fpu_ss_pkg;

   // Width of the id field held in a writeback entry; the arbiter's ID_WIDTH defaults to it.
   localparam int unsigned WB_ID_W = 4;

   typedef struct packed {
      logic [WB_ID_W-1:0] id;
      logic [4:0]         rd;
      logic [31:0]        data;
   } wb_entry_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// rtl/fpu_ss_wb_fifo.sv - DEPTH-entry FIFO of writeback entries
// Purpose: buffers CSR read results that could not go straight to the X-IF result register.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write request and entry (ignored when full unless popping the same cycle)
//   pop_i, rdata_o    read request and head entry (ignored when empty)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries, 0..DEPTH
module fpu_ss_wb_fifo
   import fpu_ss_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  wb_entry_t        wdata_i,
   input  logic             pop_i,
   output wb_entry_t        rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];

   // A pop frees the head slot this cycle, so a push into a full FIFO is accepted alongside it.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= ptr_next(wptr_q);
         end
         if (do_pop) begin
            rptr_q <= ptr_next(rptr_q);
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_ss_wb_arb.sv
// rtl/fpu_ss_wb_arb.sv - writeback arbiter merging CSR and FPU integer results onto X-IF
// Purpose: merges one-cycle CSR read pulses (buffered, never stalled) and FPU integer-destination
//   results (valid/ready) into the registered X-IF result channel; FP-destination FPU results
//   go straight to the FP register file in the same cycle.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   csr_wb_i, csr_rdata_i/rd_i/id_i     CSR result pulse and payload
//   csr_ready_o                         CSR FIFO not full (registered count based)
//   fpu_out_valid_i/ready_o             FPU result handshake
//   fpu_int_wb_i, fpu_result_i/rd_i/id_i FPU destination select and payload
//   fpr_we_o/waddr_o/wdata_o            FP regfile write port
//   x_result_*                          CV-X-IF result channel
//   overflow_o                          sticky: CSR pulse lost to a full FIFO
module fpu_ss_wb_arb
   import fpu_ss_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned ID_WIDTH = WB_ID_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                csr_wb_i,
   input  logic [31:0]         csr_rdata_i,
   input  logic [4:0]          csr_rd_i,
   input  logic [ID_WIDTH-1:0] csr_id_i,
   output logic                csr_ready_o,
   input  logic                fpu_out_valid_i,
   output logic                fpu_out_ready_o,
   input  logic                fpu_int_wb_i,
   input  logic [31:0]         fpu_result_i,
   input  logic [4:0]          fpu_rd_i,
   input  logic [ID_WIDTH-1:0] fpu_id_i,
   output logic                fpr_we_o,
   output logic [4:0]          fpr_waddr_o,
   output logic [31:0]         fpr_wdata_o,
   output logic                x_result_valid_o,
   input  logic                x_result_ready_i,
   output logic [ID_WIDTH-1:0] x_result_id_o,
   output logic [31:0]         x_result_data_o,
   output logic [4:0]          x_result_rd_o,
   output logic                x_result_we_o,
   output logic                overflow_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                valid_q, valid_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [31:0]         data_q, data_d;
   logic [4:0]          rd_q, rd_d;
   logic                ovf_q, ovf_d;

   wb_entry_t        csr_entry, head;
   logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CNT_W-1:0] fifo_cnt;
   logic             slot_free, bypass, fpu_take, csr_push;

   assign csr_entry = '{id: WB_ID_W'(csr_id_i), rd: csr_rd_i, data: csr_rdata_i};

   // Priority: buffered CSR, then live CSR, then FPU; FPU waits until no CSR result is pending
   // so CSR results are never overtaken.
   assign slot_free = !valid_q || x_result_ready_i;
   assign fifo_pop  = slot_free && !fifo_empty;
   assign bypass    = slot_free && fifo_empty && csr_wb_i;
   assign fpu_take  = slot_free && fifo_empty && !csr_wb_i && fpu_out_valid_i && fpu_int_wb_i;
   assign csr_push  = csr_wb_i && !bypass;
   assign fifo_push = csr_push;

   assign fpu_out_ready_o = fpu_int_wb_i ? (slot_free && fifo_empty && !csr_wb_i) : 1'b1;
   assign fpr_we_o        = fpu_out_valid_i && !fpu_int_wb_i;
   assign fpr_waddr_o     = fpu_rd_i;
   assign fpr_wdata_o     = fpu_result_i;
   assign csr_ready_o     = (fifo_cnt < CNT_W'(DEPTH));

   fpu_ss_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i (csr_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_comb begin
      valid_d = valid_q;
      id_d    = id_q;
      data_d  = data_q;
      rd_d    = rd_q;
      ovf_d   = ovf_q;
      if (slot_free) begin
         valid_d = fifo_pop || bypass || fpu_take;
         if (fifo_pop) begin
            id_d   = ID_WIDTH'(head.id);
            rd_d   = head.rd;
            data_d = head.data;
         end else if (bypass) begin
            id_d   = csr_id_i;
            rd_d   = csr_rd_i;
            data_d = csr_rdata_i;
         end else if (fpu_take) begin
            id_d   = fpu_id_i;
            rd_d   = fpu_rd_i;
            data_d = fpu_result_i;
         end
      end
      // Same condition under which the FIFO refuses the push.
      if (csr_push && fifo_full && !fifo_pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         data_q  <= '0;
         rd_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign x_result_valid_o = valid_q;
   assign x_result_we_o    = valid_q;
   assign x_result_id_o    = id_q;
   assign x_result_data_o  = data_q;
   assign x_result_rd_o    = rd_q;
   assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_fpu_ss_wb_arb.sv
// tb/tb_fpu_ss_wb_arb.sv - self-checking bench for fpu_ss_wb_arb
module tb_fpu_ss_wb_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_wb;
   logic [31:0] csr_rdata;
   logic [4:0]  csr_rd;
   logic [3:0]  csr_id;
   logic        csr_ready;
   logic        fpu_valid, fpu_ready, fpu_int;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_rd;
   logic [3:0]  fpu_id;
   logic        fpr_we;
   logic [4:0]  fpr_waddr;
   logic [31:0] fpr_wdata;
   logic        x_valid, x_ready, x_we, overflow;
   logic [3:0]  x_id;
   logic [31:0] x_data;
   logic [4:0]  x_rd;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   fpu_ss_wb_arb #(.DEPTH(2), .ID_WIDTH(4)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .csr_wb_i         (csr_wb),
      .csr_rdata_i      (csr_rdata),
      .csr_rd_i         (csr_rd),
      .csr_id_i         (csr_id),
      .csr_ready_o      (csr_ready),
      .fpu_out_valid_i  (fpu_valid),
      .fpu_out_ready_o  (fpu_ready),
      .fpu_int_wb_i     (fpu_int),
      .fpu_result_i     (fpu_result),
      .fpu_rd_i         (fpu_rd),
      .fpu_id_i         (fpu_id),
      .fpr_we_o         (fpr_we),
      .fpr_waddr_o      (fpr_waddr),
      .fpr_wdata_o      (fpr_wdata),
      .x_result_valid_o (x_valid),
      .x_result_ready_i (x_ready),
      .x_result_id_o    (x_id),
      .x_result_data_o  (x_data),
      .x_result_rd_o    (x_rd),
      .x_result_we_o    (x_we),
      .overflow_o       (overflow)
   );

   typedef struct {
      logic        csr_wb;
      logic [31:0] csr_data;
      logic [4:0]  csr_rd;
      logic [3:0]  csr_id;
      logic        fv;
      logic        fint;
      logic [31:0] fres;
      logic [4:0]  frd;
      logic [3:0]  fid;
      logic        xrdy;
      logic        e_frdy;
      logic        e_fwe;
      logic        e_valid;
      logic [3:0]  e_id;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_csr_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic cw, input logic [31:0] cd, input logic [4:0] crd, input logic [3:0] cid,
      input logic fv, input logic fint, input logic [31:0] fres, input logic [4:0] frd,
      input logic [3:0] fid, input logic xrdy,
      input logic e_frdy, input logic e_fwe, input logic e_valid, input logic [3:0] e_id,
      input logic [4:0] e_rd, input logic [31:0] e_data, input logic e_csr_rdy);
      vec_t v;
      v.csr_wb = cw; v.csr_data = cd; v.csr_rd = crd; v.csr_id = cid;
      v.fv = fv; v.fint = fint; v.fres = fres; v.frd = frd; v.fid = fid; v.xrdy = xrdy;
      v.e_frdy = e_frdy; v.e_fwe = e_fwe; v.e_valid = e_valid; v.e_id = e_id;
      v.e_rd = e_rd; v.e_data = e_data; v.e_csr_rdy = e_csr_rdy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_csr(input logic wb, input logic [31:0] d, input logic rdy);
      csr_wb    = wb;
      csr_rdata = d;
      csr_rd    = d[4:0];
      csr_id    = d[3:0];
      fpu_valid = 1'b0;
      fpu_int   = 1'b0;
      x_ready   = rdy;
   endtask

   initial begin
      rst = 1'b1;
      drive_csr(1'b0, 32'h0, 1'b1);
      fpu_result = '0; fpu_rd = '0; fpu_id = '0;
      tick(); tick();
      chk("reset valid", x_valid, 0);
      chk("reset we", x_we, 0);
      chk("reset id", x_id, 0);
      chk("reset data", x_data, 0);
      chk("reset rd", x_rd, 0);
      chk("reset overflow", overflow, 0);
      chk("reset csr_ready", csr_ready, 1);
      rst = 1'b0;

      //              cw cdata         crd cid fv fi fres          frd fid xr  frdy fwe val id rd  data          crdy
      vecs.push_back(mk(0, 32'h0,        0,  0, 0, 0, 32'h0,        0,  0, 1,  1,   0,  0,  0, 0,  32'h0,        1));
      vecs.push_back(mk(1, 32'hE0,       10, 3, 0, 0, 32'h0,        0,  0, 1,  1,   0,  1,  3, 10, 32'hE0,       1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 0, 0, 32'h0,        0,  0, 1,  1,   0,  0,  0, 0,  32'h0,        1));
      vecs.push_back(mk(1, 32'h1,        1,  1, 0, 0, 32'h0,        0,  0, 0,  1,   0,  1,  1, 1,  32'h1,        1));
      vecs.push_back(mk(1, 32'h2,        2,  2, 0, 0, 32'h0,        0,  0, 0,  1,   0,  1,  1, 1,  32'h1,        1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 0, 0, 32'h0,        0,  0, 1,  1,   0,  1,  2, 2,  32'h2,        1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 0, 0, 32'h0,        0,  0, 1,  1,   0,  0,  0, 0,  32'h0,        1));
      vecs.push_back(mk(1, 32'h55,       4,  4, 1, 1, 32'hFFFFFFFF, 7,  5, 1,  0,   0,  1,  4, 4,  32'h55,       1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 1, 1, 32'hFFFFFFFF, 7,  5, 1,  1,   0,  1,  5, 7,  32'hFFFFFFFF, 1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 0, 0, 32'h0,        0,  0, 1,  1,   0,  0,  0, 0,  32'h0,        1));
      vecs.push_back(mk(1, 32'hAA,       6,  6, 0, 0, 32'h0,        0,  0, 0,  1,   0,  1,  6, 6,  32'hAA,       1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 1, 0, 32'h3F800000, 5,  9, 0,  1,   1,  1,  6, 6,  32'hAA,       1));
      vecs.push_back(mk(0, 32'h0,        0,  0, 1, 1, 32'h12345678, 8,  9, 0,  0,   0,  1,  6, 6,  32'hAA,       1));

      for (int i = 0; i < vecs.size(); i++) begin
         csr_wb = vecs[i].csr_wb; csr_rdata = vecs[i].csr_data;
         csr_rd = vecs[i].csr_rd; csr_id = vecs[i].csr_id;
         fpu_valid = vecs[i].fv; fpu_int = vecs[i].fint; fpu_result = vecs[i].fres;
         fpu_rd = vecs[i].frd; fpu_id = vecs[i].fid; x_ready = vecs[i].xrdy;
         #1;
         chk($sformatf("v%0d fpu_ready", i), fpu_ready, vecs[i].e_frdy);
         chk($sformatf("v%0d fpr_we", i), fpr_we, vecs[i].e_fwe);
         if (vecs[i].e_fwe) begin
            chk($sformatf("v%0d fpr_waddr", i), fpr_waddr, vecs[i].frd);
            chk($sformatf("v%0d fpr_wdata", i), fpr_wdata, vecs[i].fres);
         end
         tick();
         chk($sformatf("v%0d valid", i), x_valid, vecs[i].e_valid);
         chk($sformatf("v%0d we", i), x_we, vecs[i].e_valid);
         chk($sformatf("v%0d csr_ready", i), csr_ready, vecs[i].e_csr_rdy);
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d id", i), x_id, vecs[i].e_id);
            chk($sformatf("v%0d rd", i), x_rd, vecs[i].e_rd);
            chk($sformatf("v%0d data", i), x_data, vecs[i].e_data);
         end
      end

      // Output still holds 0xAA with ready low; fill the FIFO.
      drive_csr(1'b1, 32'h10, 1'b0);
      tick();
      chk("fill1 data", x_data, 32'hAA);
      chk("fill1 csr_ready", csr_ready, 1);
      drive_csr(1'b1, 32'h11, 1'b0);
      tick();
      chk("fill2 csr_ready", csr_ready, 0);
      chk("fill2 overflow", overflow, 0);
      // Pop and push while full: no loss.
      drive_csr(1'b1, 32'h12, 1'b1);
      tick();
      chk("poppush data", x_data, 32'h10);
      chk("poppush csr_ready", csr_ready, 0);
      chk("poppush overflow", overflow, 0);
      // Push while full with output stalled: dropped.
      drive_csr(1'b1, 32'h13, 1'b0);
      #1;
      chk("drop csr_ready pre", csr_ready, 0);
      tick();
      chk("drop overflow", overflow, 1);
      chk("drop data held", x_data, 32'h10);
      drive_csr(1'b0, 32'h0, 1'b1);
      tick();
      chk("drain1 data", x_data, 32'h11);
      tick();
      chk("drain2 data", x_data, 32'h12);
      chk("drain2 valid", x_valid, 1);
      tick();
      chk("drain3 valid", x_valid, 0);
      chk("overflow sticky", overflow, 1);

      // Refill output plus two FIFO entries, then reset.
      drive_csr(1'b1, 32'h20, 1'b0);
      tick();
      chk("refill data", x_data, 32'h20);
      drive_csr(1'b1, 32'h21, 1'b0);
      tick();
      drive_csr(1'b1, 32'h22, 1'b0);
      tick();
      chk("refill csr_ready", csr_ready, 0);
      chk("refill valid", x_valid, 1);
      drive_csr(1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      chk("rst valid", x_valid, 0);
      chk("rst we", x_we, 0);
      chk("rst data", x_data, 0);
      chk("rst id", x_id, 0);
      chk("rst rd", x_rd, 0);
      chk("rst overflow", overflow, 0);
      chk("rst csr_ready", csr_ready, 1);
      rst = 1'b0;
      drive_csr(1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("post-rst valid %0d", k), x_valid, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
